// File: rtl/alu_result_fifo.sv
// alu_result_fifo: buffers ALU results with {C,N,Z} status flags in a small
// first-word-fall-through FIFO. The ALU cannot be stalled, so results that
// arrive while the FIFO is full are dropped and counted.
module alu_result_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_carry,
  input  logic              in_valid,
  output logic [7:0]        out_data,
  output logic [2:0]        out_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [7:0]        drop_cnt,
  input  logic              clr_ovf
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  // Each entry is {C, N, Z, data[7:0]}.
  logic [10:0]       mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [10:0]       head;
  logic [2:0]        in_flags;
  logic              push;
  logic              pop;
  logic              drop;

  // Status, handshake decode and head-entry presentation.
  always_comb begin
    full      = (count == FULL_CNT);
    empty     = (count == '0);
    out_valid = !empty;
    pop       = out_valid && out_ready;
    // A full FIFO still accepts a result when the head leaves in the same cycle.
    push      = in_valid && (!full || pop);
    drop      = in_valid && full && !pop;
    in_flags  = {in_carry, in_data[7], (in_data == 8'h00)};
    head      = mem[rd_ptr];
    out_data  = empty ? '0 : head[7:0];
    out_flags = empty ? '0 : head[10:8];
  end

  // Storage write; the array itself is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_flags, in_data};
    end
  end

  // Pointers and occupancy; pointers wrap naturally, full/empty come from count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf) begin
        drop_cnt <= 8'd1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule
